alarm_manager: RTL and testbench

ALARM_MANAGER -- requirements
Module: alarm_manager

---
 rtl/alarm_manager.sv | 155 +++++++++++++++
 tb/tb_alarm_manager.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_manager.sv
// Per-channel fault classifier alarm manager: debounces qualified fault/healthy
// results into alarm flags, with sticky interrupt status and a shared irq pulse.
module alarm_manager #(
  parameter int NUM_CH  = 4,
  parameter int CLASS_W = 2,
  parameter int CONF_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         classification_done,
  input  logic [NUM_CH*CLASS_W-1:0] class_id,
  input  logic [NUM_CH*CONF_W-1:0]  confidence,
  input  logic [CONF_W-1:0]         alarm_threshold,
  input  logic [CNT_W-1:0]          fault_count_cfg,
  input  logic [CNT_W-1:0]          clear_count_cfg,
  input  logic                      latch_mode,
  input  logic [NUM_CH-1:0]         irq_mask,
  input  logic [NUM_CH-1:0]         ack,
  output logic [NUM_CH-1:0]         alarm_active,
  output logic [NUM_CH-1:0]         irq_status,
  output logic                      irq,
  output logic [NUM_CH*CLASS_W-1:0] last_fault_class,
  output logic                      any_alarm
);

  typedef enum logic [1:0] {ST_NORMAL, ST_SUSPECT, ST_ALARM, ST_CLEARING} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // A zero threshold count would never be reached, so it behaves as one.
  logic [CNT_W-1:0] fault_eff;
  logic [CNT_W-1:0] clear_eff;
  assign fault_eff = (fault_count_cfg == '0) ? CNT_ONE : fault_count_cfg;
  assign clear_eff = (clear_count_cfg == '0) ? CNT_ONE : clear_count_cfg;

  logic [NUM_CH-1:0] irq_set_vec;
  logic              irq_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t             state_reg, state_next;
      logic [CNT_W-1:0]   fault_cnt_reg, fault_cnt_next;
      logic [CNT_W-1:0]   heal_cnt_reg, heal_cnt_next;
      logic [CLASS_W-1:0] class_reg, class_next;
      logic               alarm_reg, alarm_next;
      logic               irq_status_reg, irq_status_next;
      logic               irq_set;
      logic [CLASS_W-1:0] cls;
      logic [CONF_W-1:0]  conf;
      logic               ev_fault, ev_heal, ev_low, ack_drop;

      assign cls      = class_id[gi*CLASS_W +: CLASS_W];
      assign conf     = confidence[gi*CONF_W +: CONF_W];
      assign ev_fault = classification_done[gi] && (cls != '0) && (conf >= alarm_threshold);
      assign ev_heal  = classification_done[gi] && (cls == '0) && (conf >= alarm_threshold);
      assign ev_low   = classification_done[gi] && (conf < alarm_threshold);
      // A latched alarm being acknowledged swallows whatever else arrives that cycle.
      assign ack_drop = latch_mode && ack[gi] && (state_reg == ST_ALARM);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg      <= ST_NORMAL;
          fault_cnt_reg  <= '0;
          heal_cnt_reg   <= '0;
          class_reg      <= '0;
          alarm_reg      <= 1'b0;
          irq_status_reg <= 1'b0;
        end else begin
          state_reg      <= state_next;
          fault_cnt_reg  <= fault_cnt_next;
          heal_cnt_reg   <= heal_cnt_next;
          class_reg      <= class_next;
          alarm_reg      <= alarm_next;
          irq_status_reg <= irq_status_next;
        end
      end

      always_comb begin
        state_next     = state_reg;
        fault_cnt_next = fault_cnt_reg;
        heal_cnt_next  = heal_cnt_reg;
        class_next     = class_reg;
        if (ack_drop) begin
          state_next = ST_NORMAL;
        end else begin
          if (ev_fault) class_next = cls;
          case (state_reg)
            ST_NORMAL: begin
              if (ev_fault) begin
                fault_cnt_next = CNT_ONE;
                state_next     = (CNT_ONE >= fault_eff) ? ST_ALARM : ST_SUSPECT;
              end
            end
            ST_SUSPECT: begin
              if (ev_fault) begin
                fault_cnt_next = sat_inc(fault_cnt_reg);
                if (sat_inc(fault_cnt_reg) >= fault_eff) state_next = ST_ALARM;
              end else if (ev_heal || ev_low) begin
                fault_cnt_next = '0;
                state_next     = ST_NORMAL;
              end
            end
            ST_ALARM: begin
              if (ev_heal && !latch_mode) begin
                heal_cnt_next = CNT_ONE;
                state_next    = (CNT_ONE >= clear_eff) ? ST_NORMAL : ST_CLEARING;
              end
            end
            ST_CLEARING: begin
              if (latch_mode || ev_fault || ev_low) begin
                heal_cnt_next = '0;
                state_next    = ST_ALARM;
              end else if (ev_heal) begin
                heal_cnt_next = sat_inc(heal_cnt_reg);
                if (sat_inc(heal_cnt_reg) >= clear_eff) state_next = ST_NORMAL;
              end
            end
            default: state_next = ST_NORMAL;
          endcase
        end
        if (state_next == ST_NORMAL) begin
          fault_cnt_next = '0;
          heal_cnt_next  = '0;
        end
      end

      // Only a fresh alarm raises status; bouncing back from CLEARING does not.
      always_comb begin
        alarm_next      = (state_next == ST_ALARM) || (state_next == ST_CLEARING);
        irq_set         = ((state_reg == ST_NORMAL) || (state_reg == ST_SUSPECT)) &&
                          (state_next == ST_ALARM);
        irq_status_next = irq_set ? 1'b1 : (ack[gi] ? 1'b0 : irq_status_reg);
      end

      assign alarm_active[gi]                            = alarm_reg;
      assign irq_status[gi]                              = irq_status_reg;
      assign irq_set_vec[gi]                             = irq_set;
      assign last_fault_class[gi*CLASS_W +: CLASS_W]     = class_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_reg <= 1'b0;
    else     irq_reg <= |(irq_set_vec & irq_mask);
  end

  assign irq       = irq_reg;
  assign any_alarm = |alarm_active;

endmodule

// File: tb/tb_alarm_manager.sv
// Bench for alarm_manager: directed scenarios plus random traffic, all checked
// against a behavioural run-length model of alarm raising and clearing.
module tb_alarm_manager;
  localparam int NC = 4, CW = 2, FW = 8, NW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NC-1:0]    done, irq_mask, ack;
  logic [NC*CW-1:0] class_id;
  logic [NC*FW-1:0] confidence;
  logic [FW-1:0]    thr;
  logic [NW-1:0]    fcfg, ccfg;
  logic             latch;
  logic [NC-1:0]    alarm_active, irq_status;
  logic             irq, any_alarm;
  logic [NC*CW-1:0] last_fault_class;

  alarm_manager #(.NUM_CH(NC), .CLASS_W(CW), .CONF_W(FW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .classification_done(done), .class_id(class_id),
    .confidence(confidence), .alarm_threshold(thr), .fault_count_cfg(fcfg),
    .clear_count_cfg(ccfg), .latch_mode(latch), .irq_mask(irq_mask), .ack(ack),
    .alarm_active(alarm_active), .irq_status(irq_status), .irq(irq),
    .last_fault_class(last_fault_class), .any_alarm(any_alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: an alarm flag plus run lengths of consecutive faults (while quiet)
  // and consecutive healthy results (while alarmed).
  bit          m_alarm[NC];
  int          m_run[NC];
  int          m_heal[NC];
  logic [CW-1:0] m_cls[NC];
  logic [NC-1:0] m_stat;
  logic        m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_alarm[c] = 0; m_run[c] = 0; m_heal[c] = 0; m_cls[c] = '0;
    end
    m_stat = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    int feff, ceff;
    logic [NC-1:0] raise;
    logic [CW-1:0] cl;
    logic [FW-1:0] cf;
    bit qual, flt, hl, low;
    feff  = (fcfg == 0) ? 1 : int'(fcfg);
    ceff  = (ccfg == 0) ? 1 : int'(ccfg);
    raise = '0;
    for (int c = 0; c < NC; c++) begin
      cl   = class_id[c*CW +: CW];
      cf   = confidence[c*FW +: FW];
      qual = done[c] && (cf >= thr);
      flt  = qual && (cl != 0);
      hl   = qual && (cl == 0);
      low  = done[c] && (cf < thr);
      if (m_alarm[c] && latch && ack[c] && m_heal[c] == 0) begin
        m_alarm[c] = 0; m_run[c] = 0;
      end else begin
        if (flt) m_cls[c] = cl;
        if (!m_alarm[c]) begin
          if (flt) begin
            m_run[c]++;
            if (m_run[c] >= feff) begin m_alarm[c] = 1; m_run[c] = 0; raise[c] = 1'b1; end
          end else if (hl || low) m_run[c] = 0;
        end else if (latch) begin
          m_heal[c] = 0;
        end else if (hl) begin
          m_heal[c]++;
          if (m_heal[c] >= ceff) begin m_alarm[c] = 0; m_heal[c] = 0; end
        end else if (flt || low) begin
          m_heal[c] = 0;
        end
      end
    end
    m_stat = raise | (m_stat & ~ack);
    m_irq  = |(raise & irq_mask);
  endtask

  task automatic check_all(input string tag);
    logic [NC-1:0]    ea;
    logic [NC*CW-1:0] ec;
    for (int c = 0; c < NC; c++) begin
      ea[c] = m_alarm[c];
      ec[c*CW +: CW] = m_cls[c];
    end
    check({tag, ".alarm"}, 32'(alarm_active), 32'(ea));
    check({tag, ".status"}, 32'(irq_status), 32'(m_stat));
    check({tag, ".irq"}, 32'(irq), 32'(m_irq));
    check({tag, ".class"}, 32'(last_fault_class), 32'(ec));
    check({tag, ".any"}, 32'(any_alarm), 32'(|ea));
  endtask

  task automatic set_ev(input int c, input logic [CW-1:0] cl, input logic [FW-1:0] cf);
    done[c] = 1'b1;
    class_id[c*CW +: CW]   = cl;
    confidence[c*FW +: FW] = cf;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
    @(negedge clk);
    done = '0; ack = '0;
  endtask

  initial begin
    rst = 1'b1; done = '0; ack = '0; class_id = '0; confidence = '0;
    thr = 8'd128; fcfg = 4'd3; ccfg = 4'd2; latch = 1'b0; irq_mask = 4'hf;
    model_reset();
    #1 check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Three qualified faults raise the alarm on ch0.
    for (int i = 0; i < 3; i++) begin set_ev(0, 2'd2, 8'd200); step("r40"); end
    check("r40_alarm", 32'(alarm_active), 32'h1);
    check("r40_irq", 32'(irq), 32'h1);
    check("r40_status", 32'(irq_status), 32'h1);
    check("r40_class", 32'(last_fault_class[1:0]), 32'h2);
    step("r40_idle");
    check("r40_pulse_end", 32'(irq), 32'h0);
    ack[0] = 1'b1; step("r40_ack");

    // Hysteresis clear with an interrupting fault.
    set_ev(0, 2'd0, 8'd200); step("r42_h1");
    set_ev(0, 2'd1, 8'd200); step("r42_f");
    check("r42_noirq", 32'(irq), 32'h0);
    set_ev(0, 2'd0, 8'd200); step("r42_h2");
    check("r42_clearing", 32'(alarm_active), 32'h1);
    set_ev(0, 2'd0, 8'd200); step("r42_h3");
    check("r42_cleared", 32'(alarm_active), 32'h0);

    // A low-confidence result breaks the fault run.
    set_ev(0, 2'd2, 8'd200); step("r41_f1");
    set_ev(0, 2'd2, 8'd200); step("r41_f2");
    set_ev(0, 2'd2, 8'd50);  step("r41_low");
    set_ev(0, 2'd2, 8'd200); step("r41_f3");
    set_ev(0, 2'd2, 8'd200); step("r41_f4");
    check("r41_noalarm", 32'(alarm_active), 32'h0);
    check("r41_noirq", 32'(irq), 32'h0);

    // Latched alarm ignores healthy results until acknowledged.
    set_ev(0, 2'd2, 8'd200); step("r43_f5");
    latch = 1'b1;
    for (int i = 0; i < 5; i++) begin set_ev(0, 2'd0, 8'd220); step("r43_h"); end
    check("r43_held", 32'(alarm_active), 32'h1);
    ack[0] = 1'b1; step("r43_ack");
    check("r43_alarm", 32'(alarm_active), 32'h0);
    check("r43_status", 32'(irq_status), 32'h0);

    // Simultaneous alarms on ch1/ch2, masked and unmasked.
    irq_mask = 4'b0101;
    for (int i = 0; i < 3; i++) begin set_ev(1, 2'd1, 8'd150); set_ev(2, 2'd3, 8'd150); step("r44a"); end
    check("r44a_status", 32'(irq_status), 32'h6);
    check("r44a_irq", 32'(irq), 32'h1);
    step("r44a_idle");
    ack = 4'b0110; step("r44a_ack");
    irq_mask = 4'b1001;
    for (int i = 0; i < 3; i++) begin set_ev(1, 2'd1, 8'd150); set_ev(2, 2'd3, 8'd150); step("r44b"); end
    check("r44b_status", 32'(irq_status), 32'h6);
    check("r44b_irq", 32'(irq), 32'h0);
    ack = 4'b0110; step("r44b_ack");

    // Asynchronous reset mid-alarm, then a single fault with a zero count cfg.
    latch = 1'b0; irq_mask = 4'hf;
    for (int i = 0; i < 3; i++) begin set_ev(3, 2'd1, 8'd255); step("r45_f"); end
    check("r45_alarm", 32'(alarm_active), 32'h8);
    #2 rst = 1'b1;
    #1;
    check("r45_rst_alarm", 32'(alarm_active), 32'h0);
    check("r45_rst_status", 32'(irq_status), 32'h0);
    check("r45_rst_class", 32'(last_fault_class), 32'h0);
    check("r45_rst_any", 32'(any_alarm), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; fcfg = 4'd0;
    set_ev(3, 2'd2, 8'd200); step("r45_zero");
    check("r45_zero_alarm", 32'(alarm_active), 32'h8);
    check("r45_zero_irq", 32'(irq), 32'h1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) begin
        fcfg = 4'($urandom_range(0, 4));
        ccfg = 4'($urandom_range(0, 3));
        irq_mask = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) latch = ~latch;
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 1) == 1)
          set_ev(c, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        ack[c] = ($urandom_range(0, 7) == 0);
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
